// File: rtl/simple_dual_port_ram_fifo_controller_fifo_pointer.sv
// Wrapping FIFO pointer: one wrap bit above the address bits, with increment and load.
module simple_dual_port_ram_fifo_controller_fifo_pointer #(
    parameter int PTR_WIDTH = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_increment,
    input  logic                 i_load,
    input  logic [PTR_WIDTH-1:0] i_load_value,
    output logic [PTR_WIDTH-1:0] o_pointer
);

    logic [PTR_WIDTH-1:0] r_pointer;

    // Load takes priority over increment; the wrap bit rolls over naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pointer <= {PTR_WIDTH{1'b0}};
        end else if (i_load) begin
            r_pointer <= i_load_value;
        end else if (i_increment) begin
            r_pointer <= r_pointer + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_pointer <= r_pointer;
        end
    end

    assign o_pointer = r_pointer;

endmodule

// File: rtl/simple_dual_port_ram_fifo_controller.sv
// FIFO controller around an external simple dual-port RAM with 1-cycle registered read.
// Optional flush input enabled by SIMPLE_DUAL_PORT_RAM_FIFO_CONTROLLER_FLUSH_EN.
module simple_dual_port_ram_fifo_controller #(
    parameter  int WIDTH         = 8,
    parameter  int DEPTH         = 16,
    localparam int ADDRESS_WIDTH = $clog2(DEPTH),
    localparam int LEVEL_WIDTH   = $clog2(DEPTH + 2)
) (
    input  logic                     clock,
    input  logic                     reset,
`ifdef SIMPLE_DUAL_PORT_RAM_FIFO_CONTROLLER_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic                     write_valid,
    output logic                     write_ready,
    input  logic [WIDTH-1:0]         write_data,
    output logic                     read_valid,
    input  logic                     read_ready,
    output logic [WIDTH-1:0]         read_data,
    output logic                     ram_write_enable,
    output logic [ADDRESS_WIDTH-1:0] ram_write_address,
    output logic [WIDTH-1:0]         ram_write_data,
    output logic                     ram_read_enable,
    output logic [ADDRESS_WIDTH-1:0] ram_read_address,
    input  logic [WIDTH-1:0]         ram_read_data,
    output logic [LEVEL_WIDTH-1:0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = ADDRESS_WIDTH + 1;

    logic [PW-1:0] w_write_pointer;
    logic [PW-1:0] w_read_pointer;
    logic [PW-1:0] w_occupancy;
    logic          w_ram_full;
    logic          w_ram_empty;
    logic          w_push;
    logic          w_flush;
    logic          w_output_valid_next;
    logic          r_output_valid;

`ifdef SIMPLE_DUAL_PORT_RAM_FIFO_CONTROLLER_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_ram_full  = (w_write_pointer[ADDRESS_WIDTH-1:0] == w_read_pointer[ADDRESS_WIDTH-1:0])
                      && (w_write_pointer[ADDRESS_WIDTH] != w_read_pointer[ADDRESS_WIDTH]);
    assign w_ram_empty = (w_write_pointer == w_read_pointer);
    assign w_occupancy = w_write_pointer - w_read_pointer;

    // Status depends only on registered pointers, so a same-cycle pop never frees a push slot.
    assign write_ready       = !w_ram_full && !w_flush;
    assign w_push            = write_valid && write_ready;
    assign ram_write_enable  = w_push;
    assign ram_write_address = w_write_pointer[ADDRESS_WIDTH-1:0];
    assign ram_write_data    = write_data;

    // Prefetch into the RAM output register whenever it is free or being consumed.
    assign ram_read_enable  = !w_ram_empty && (!r_output_valid || read_ready) && !w_flush;
    assign ram_read_address = w_read_pointer[ADDRESS_WIDTH-1:0];
    assign read_data        = ram_read_data;
    assign read_valid       = r_output_valid;

    // Next state of the output-stage valid flag.
    always_comb begin
        w_output_valid_next = r_output_valid;
        if (w_flush) begin
            w_output_valid_next = 1'b0;
        end else if (ram_read_enable) begin
            w_output_valid_next = 1'b1;
        end else if (read_ready) begin
            w_output_valid_next = 1'b0;
        end else begin
            w_output_valid_next = r_output_valid;
        end
    end

    // Output-stage valid register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_output_valid <= 1'b0;
        end else begin
            r_output_valid <= w_output_valid_next;
        end
    end

    simple_dual_port_ram_fifo_controller_fifo_pointer #(.PTR_WIDTH(PW)) u_write_pointer (
        .clock        (clock),
        .reset        (reset),
        .i_increment  (w_push),
        .i_load       (1'b0),
        .i_load_value ({PW{1'b0}}),
        .o_pointer    (w_write_pointer)
    );

    // A flush discards everything by snapping the read pointer onto the write pointer.
    simple_dual_port_ram_fifo_controller_fifo_pointer #(.PTR_WIDTH(PW)) u_read_pointer (
        .clock        (clock),
        .reset        (reset),
        .i_increment  (ram_read_enable),
        .i_load       (w_flush),
        .i_load_value (w_write_pointer),
        .o_pointer    (w_read_pointer)
    );

    assign level = LEVEL_WIDTH'(w_occupancy) + LEVEL_WIDTH'(r_output_valid);
    assign empty = (level == {LEVEL_WIDTH{1'b0}});
    assign full  = w_ram_full;

endmodule
